nco_sine: RTL and testbench



---
 rtl/nco_pkg.sv | 31 +++
 rtl/sine_quarter_rom.sv | 22 ++
 rtl/nco_sine.sv | 152 +++++++++++++++
 tb/tb_nco_sine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants and the elaboration-time quarter-sine table generator for nco_sine.
// The quarter-wave table is computed here instead of being read from a .mem file.
package nco_pkg;

    localparam int PHASE_BITS    = 10;
    localparam int LUT_ADDR_BITS = 8;
    localparam int LUT_DATA_BITS = 9;
    localparam int MIDSCALE      = 512;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam real PI_HALF = 1.5707963267948966;

    // q[k] = round(511 * sin(pi/2 * (k + 0.5) / 256)); the Taylor series converges well inside double precision
    function automatic logic [LUT_DATA_BITS-1:0] quarter_sine(input int k);
        real x;
        real term;
        real sum;
        x    = PI_HALF * (real'(k) + 0.5) / real'(2 ** LUT_ADDR_BITS);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return LUT_DATA_BITS'($rtoi(sum * real'(2 ** LUT_DATA_BITS - 1) + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous-read 256x9 quarter-wave sine ROM; contents fixed at elaboration.
module sine_quarter_rom
    import nco_pkg::*;
(
    input  logic                     clk,
    input  logic [LUT_ADDR_BITS-1:0] addr,
    output logic [LUT_DATA_BITS-1:0] data
);

    logic [LUT_DATA_BITS-1:0] rom_q [2 ** LUT_ADDR_BITS];

    for (genvar k = 0; k < 2 ** LUT_ADDR_BITS; k++) begin : g_rom
        localparam logic [LUT_DATA_BITS-1:0] ROM_VAL = quarter_sine(k);
        assign rom_q[k] = ROM_VAL;
    end

    // No reset on the read register so the array maps onto block RAM
    always_ff @(posedge clk) begin
        data <= rom_q[addr];
    end

endmodule

// File: rtl/nco_sine.sv
// Numerically controlled sine source: prescaled phase accumulator, quarter-wave ROM, 10-bit output.
// Optional phase dither before truncation is enabled by defining NCO_PHASE_DITHER_EN.
module nco_sine
    import nco_pkg::*;
#(
    parameter int                  CLK_DIV  = 48,
    parameter int                  ACC_BITS = 24,
    parameter logic [ACC_BITS-1:0] TW_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                phase_clr,
    input  logic [ACC_BITS-1:0] tw_data,
    input  logic                tw_valid,
    output logic                tw_ready,
    output logic [9:0]          out,
    output logic                out_valid,
    output logic                wrap
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]        count;
    logic                    tick;
    logic                    step;
    logic                    accept;
    logic                    pending;
    logic [ACC_BITS-1:0]     tw_pending;
    logic [ACC_BITS-1:0]     tw_active;
    logic [ACC_BITS-1:0]     eff_tw;
    logic [ACC_BITS-1:0]     acc;
    logic [ACC_BITS:0]       sum;
    logic [PHASE_BITS-1:0]   phase_idx;

    logic                    s1_valid;
    logic                    s1_wrap;
    logic [PHASE_BITS-1:0]   s1_idx;
    logic [LUT_ADDR_BITS-1:0] rom_addr;
    logic [LUT_DATA_BITS-1:0] rom_q;
    logic                    s2_valid;
    logic                    s2_wrap;
    logic                    s2_neg;

    // Handshake: a word moves when tw_valid && tw_ready at a rising edge; tw_valid is ignored while a word is pending
    assign tick     = enable && (count == CNT_MAX);
    assign step     = tick && !phase_clr;
    assign tw_ready = !pending;
    assign accept   = tw_valid && tw_ready;
    assign eff_tw   = pending ? tw_pending : tw_active;
    assign sum      = {1'b0, acc} + {1'b0, eff_tw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (phase_clr) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            tw_pending <= '0;
            tw_active  <= TW_RESET;
        end else if (accept) begin
            pending    <= 1'b1;
            tw_pending <= tw_data;
        end else if (step && pending) begin
            pending   <= 1'b0;
            tw_active <= tw_pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (phase_clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[ACC_BITS-1:0];
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    logic [15:0]         lfsr;
    logic [ACC_BITS-1:0] dith_phase;
    logic                unused_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // Dither only perturbs the table index; the accumulator itself stays exact
    assign dith_phase  = acc + {{PHASE_BITS{1'b0}}, lfsr[ACC_BITS-PHASE_BITS-1:0]};
    assign phase_idx   = dith_phase[ACC_BITS-1 -: PHASE_BITS];
    assign unused_lfsr = ^lfsr;
`else
    assign phase_idx = acc[ACC_BITS-1 -: PHASE_BITS];
`endif

    // Each sample is the phase held at its tick; the tick's addition lands in acc alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_wrap  <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= step;
            if (step) begin
                s1_idx  <= phase_idx;
                s1_wrap <= sum[ACC_BITS];
            end
        end
    end

    assign rom_addr = s1_idx[8] ? ~s1_idx[7:0] : s1_idx[7:0];

    sine_quarter_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_wrap   <= 1'b0;
            s2_neg    <= 1'b0;
            out       <= 10'(MIDSCALE);
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_wrap   <= s1_valid && s1_wrap;
            s2_neg    <= s1_idx[9];
            out_valid <= s2_valid;
            wrap      <= s2_valid && s2_wrap;
            if (s2_valid) begin
                out <= s2_neg ? (10'd511 - {1'b0, rom_q}) : (10'd512 + {1'b0, rom_q});
            end
        end
    end

endmodule

// File: tb/tb_nco_sine.sv
// Directed bench for nco_sine with CLK_DIV=4, ACC_BITS=24, TW_RESET=2^14 (one table index per tick).
// Every sample shows the phase captured at its tick; strobes land three cycles after the tick.
module tb_nco_sine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        phase_clr = 1'b0;
    logic [23:0] tw_data = '0;
    logic        tw_valid = 1'b0;
    logic        tw_ready;
    logic [9:0]  out;
    logic        out_valid;
    logic        wrap;

    int          vectors = 0;
    int          miscompares = 0;
    int          sc_q[$];
    logic [9:0]  so_q[$];
    int          wraps = 0;

    always #5 clk = ~clk;

    nco_sine #(
        .CLK_DIV  (4),
        .ACC_BITS (24),
        .TW_RESET (24'h004000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .phase_clr (phase_clr),
        .tw_data   (tw_data),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .out       (out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock; logs any strobe seen in local cycle c
    task automatic clk_step(input int c);
        @(posedge clk);
        #1;
        if (out_valid) begin
            sc_q.push_back(c);
            so_q.push_back(out);
            if (wrap) wraps++;
        end
    endtask

    task automatic clear_log();
        sc_q.delete();
        so_q.delete();
        wraps = 0;
    endtask

    // Returns clocks until the next strobe; limit+1 means it never came
    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; enable = 1'b0; phase_clr = 1'b0; tw_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out !== 10'd512) begin miscompares++; $display("FAIL reset_out: got %0d expected 512", out); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        vectors++; if (tw_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tw_ready: got %b expected 1", tw_ready); end
`ifdef NCO_PHASE_DITHER_EN
        vectors++; if (dut.lfsr !== 16'hACE1) begin miscompares++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr); end
`endif
        rst_n = 1'b1; enable = 1'b1;
        wait_strobe(20, n);
        vectors++; if (n !== 6) begin miscompares++; $display("FAIL first_latency: got %0d expected 6", n); end
        vectors++; if (out !== 10'd514) begin miscompares++; $display("FAIL first_sample: got %0d expected 514", out); end
        vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL first_wrap: got %b expected 0", wrap); end
    endtask

    task automatic test_sweep();
        int n;
        int bad = 0;
        int wrap_k = -1;
        int lwraps = 0;
        for (int k = 1; k <= 1024; k++) begin
            wait_strobe(8, n);
            if (n !== 4) bad++;
            if (n > 8) break;
            if (wrap) begin lwraps++; wrap_k = k; end
            if (k == 128) begin vectors++; if (out !== 10'd874) begin miscompares++; $display("FAIL sweep_idx128: got %0d expected 874", out); end end
            if (k == 256) begin vectors++; if (out !== 10'd1023) begin miscompares++; $display("FAIL sweep_idx256: got %0d expected 1023", out); end end
            if (k == 384) begin vectors++; if (out !== 10'd872) begin miscompares++; $display("FAIL sweep_idx384: got %0d expected 872", out); end end
            if (k == 512) begin vectors++; if (out !== 10'd509) begin miscompares++; $display("FAIL sweep_idx512: got %0d expected 509", out); end end
            if (k == 768) begin vectors++; if (out !== 10'd0) begin miscompares++; $display("FAIL sweep_idx768: got %0d expected 0", out); end end
            if (k == 1023) begin vectors++; if (out !== 10'd509) begin miscompares++; $display("FAIL sweep_idx1023: got %0d expected 509", out); end end
            if (k == 1024) begin vectors++; if (out !== 10'd514) begin miscompares++; $display("FAIL sweep_idx1024: got %0d expected 514", out); end end
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL sweep_cadence: got %0d bad intervals expected 0", bad); end
        vectors++; if (lwraps !== 1) begin miscompares++; $display("FAIL sweep_wrap_count: got %0d expected 1", lwraps); end
        vectors++; if (wrap_k !== 1023) begin miscompares++; $display("FAIL sweep_wrap_pos: got %0d expected 1023", wrap_k); end
    endtask

    // Entry and exit are the cycle just after a strobe; the prescaler count is 2 there
    task automatic test_handshake();
        clear_log();
        for (int c = 1; c <= 16; c++) begin
            clk_step(c);
            if (c == 2) begin
                vectors++; if (tw_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ready_idle: got %b expected 1", tw_ready); end
                tw_valid = 1'b1; tw_data = 24'h008000;
            end
            if (c == 3) begin
                vectors++; if (tw_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready_pending: got %b expected 0", tw_ready); end
                tw_data = 24'h123456;
            end
            if (c == 5) begin
                vectors++; if (tw_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready_hold: got %b expected 0", tw_ready); end
            end
            if (c == 6) begin
                vectors++; if (tw_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ready_after_tick: got %b expected 1", tw_ready); end
                tw_valid = 1'b0;
            end
        end
        vectors++; if (sc_q.size() !== 4) begin miscompares++; $display("FAIL hs_strobe_count: got %0d expected 4", sc_q.size()); end
        vectors++; if (so_q[0] !== 10'd517) begin miscompares++; $display("FAIL hs_s0: got %0d expected 517", so_q[0]); end
        vectors++; if (so_q[1] !== 10'd520) begin miscompares++; $display("FAIL hs_s1: got %0d expected 520", so_q[1]); end
        vectors++; if (so_q[2] !== 10'd526) begin miscompares++; $display("FAIL hs_s2: got %0d expected 526", so_q[2]); end
        vectors++; if (so_q[3] !== 10'd532) begin miscompares++; $display("FAIL hs_s3: got %0d expected 532", so_q[3]); end
    endtask

    task automatic test_tick_accept();
        clear_log();
        for (int c = 1; c <= 12; c++) begin
            clk_step(c);
            if (c == 1) begin tw_valid = 1'b1; tw_data = 24'h004000; end
            if (c == 2) begin
                vectors++; if (tw_ready !== 1'b0) begin miscompares++; $display("FAIL ta_ready: got %b expected 0", tw_ready); end
                tw_valid = 1'b0;
            end
        end
        vectors++; if (sc_q.size() !== 3) begin miscompares++; $display("FAIL ta_strobe_count: got %0d expected 3", sc_q.size()); end
        vectors++; if (so_q[0] !== 10'd539) begin miscompares++; $display("FAIL ta_s0: got %0d expected 539", so_q[0]); end
        vectors++; if (so_q[1] !== 10'd545) begin miscompares++; $display("FAIL ta_s1: got %0d expected 545", so_q[1]); end
        vectors++; if (so_q[2] !== 10'd548) begin miscompares++; $display("FAIL ta_s2: got %0d expected 548", so_q[2]); end
    endtask

    task automatic test_phase_clr();
        clear_log();
        for (int c = 1; c <= 12; c++) begin
            clk_step(c);
            if (c == 1) phase_clr = 1'b1;
            if (c == 2) phase_clr = 1'b0;
        end
        vectors++; if (sc_q.size() !== 2) begin miscompares++; $display("FAIL clr_tick_count: got %0d expected 2", sc_q.size()); end
        vectors++; if (sc_q[0] !== 8) begin miscompares++; $display("FAIL clr_tick_cycle: got %0d expected 8", sc_q[0]); end
        vectors++; if (so_q[0] !== 10'd514) begin miscompares++; $display("FAIL clr_tick_s0: got %0d expected 514", so_q[0]); end
        vectors++; if (so_q[1] !== 10'd517) begin miscompares++; $display("FAIL clr_tick_s1: got %0d expected 517", so_q[1]); end
        clear_log();
        for (int c = 1; c <= 14; c++) begin
            clk_step(c);
            if (c == 3) phase_clr = 1'b1;
            if (c == 4) phase_clr = 1'b0;
        end
        vectors++; if (sc_q.size() !== 3) begin miscompares++; $display("FAIL clr_mid_count: got %0d expected 3", sc_q.size()); end
        vectors++; if (so_q[0] !== 10'd520) begin miscompares++; $display("FAIL clr_mid_inflight: got %0d expected 520", so_q[0]); end
        vectors++; if (sc_q[1] !== 10) begin miscompares++; $display("FAIL clr_mid_cycle: got %0d expected 10", sc_q[1]); end
        vectors++; if (so_q[1] !== 10'd514) begin miscompares++; $display("FAIL clr_mid_s1: got %0d expected 514", so_q[1]); end
        vectors++; if (so_q[2] !== 10'd517) begin miscompares++; $display("FAIL clr_mid_s2: got %0d expected 517", so_q[2]); end
    endtask

    task automatic test_enable();
        int ochg = 0;
        clear_log();
        enable = 1'b0;
        for (int c = 1; c <= 108; c++) begin
            clk_step(c);
            if (c <= 100 && out !== 10'd517) ochg++;
            if (c == 10) begin tw_valid = 1'b1; tw_data = 24'h008000; end
            if (c == 11) begin
                vectors++; if (tw_ready !== 1'b0) begin miscompares++; $display("FAIL en_accept: got %b expected 0", tw_ready); end
                tw_valid = 1'b0;
            end
            if (c == 100) enable = 1'b1;
        end
        vectors++; if (ochg !== 0) begin miscompares++; $display("FAIL en_out_hold: got %0d changes expected 0", ochg); end
        vectors++; if (sc_q.size() !== 2) begin miscompares++; $display("FAIL en_strobe_count: got %0d expected 2", sc_q.size()); end
        vectors++; if (sc_q[0] !== 104) begin miscompares++; $display("FAIL en_resume_cycle: got %0d expected 104", sc_q[0]); end
        vectors++; if (so_q[0] !== 10'd520) begin miscompares++; $display("FAIL en_s0: got %0d expected 520", so_q[0]); end
        vectors++; if (so_q[1] !== 10'd526) begin miscompares++; $display("FAIL en_s1: got %0d expected 526", so_q[1]); end
        vectors++; if (tw_ready !== 1'b1) begin miscompares++; $display("FAIL en_ready_end: got %b expected 1", tw_ready); end
    endtask

    task automatic test_zero_tw();
        int bad = 0;
        clear_log();
        for (int c = 1; c <= 40; c++) begin
            clk_step(c);
            if (c == 1) begin tw_valid = 1'b1; tw_data = 24'h000000; end
            if (c == 2) tw_valid = 1'b0;
        end
        for (int i = 1; i < so_q.size(); i++) if (so_q[i] !== 10'd539) bad++;
        vectors++; if (sc_q.size() !== 10) begin miscompares++; $display("FAIL zero_strobe_count: got %0d expected 10", sc_q.size()); end
        vectors++; if (so_q[0] !== 10'd532) begin miscompares++; $display("FAIL zero_s0: got %0d expected 532", so_q[0]); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL zero_constant: got %0d differing samples expected 0", bad); end
        vectors++; if (wraps !== 0) begin miscompares++; $display("FAIL zero_wrap: got %0d expected 0", wraps); end
    endtask

    task automatic test_reset_mid();
        int n;
        enable = 1'b0;
        tw_valid = 1'b1; tw_data = 24'h010000;
        @(posedge clk);
        #1;
        tw_valid = 1'b0;
        vectors++; if (tw_ready !== 1'b0) begin miscompares++; $display("FAIL rm_pending: got %b expected 0", tw_ready); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (out !== 10'd512) begin miscompares++; $display("FAIL rm_out: got %0d expected 512", out); end
        vectors++; if (tw_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b expected 1", tw_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; enable = 1'b1;
        wait_strobe(20, n);
        vectors++; if (n !== 6) begin miscompares++; $display("FAIL rm_latency: got %0d expected 6", n); end
        vectors++; if (out !== 10'd514) begin miscompares++; $display("FAIL rm_s0: got %0d expected 514", out); end
        wait_strobe(8, n);
        vectors++; if (out !== 10'd517) begin miscompares++; $display("FAIL rm_s1: got %0d expected 517", out); end
    endtask

`ifdef NCO_PHASE_DITHER_EN
    function automatic int model_out(input int i);
        int  quad;
        int  a;
        int  k;
        int  q;
        real x;
        quad = (i >> 8) & 3;
        a    = i & 255;
        k    = (quad & 1) ? 255 - a : a;
        x    = 3.141592653589793 / 2.0 * (real'(k) + 0.5) / 256.0;
        q    = $rtoi(511.0 * $sin(x) + 0.5);
        return (quad & 2) ? 511 - q : 512 + q;
    endfunction

    task automatic test_dither();
        int j = 0;
        int diffs = 0;
        int idx;
        int lo;
        int hi;
        clear_log();
        for (int c = 1; c <= 268; c++) begin
            clk_step(c);
            if (c == 2) begin tw_valid = 1'b1; tw_data = 24'h006001; end
            if (c == 3) tw_valid = 1'b0;
            if (c == 7) phase_clr = 1'b1;
            if (c == 8) phase_clr = 1'b0;
        end
        for (int i = 0; i < sc_q.size(); i++) begin
            if (sc_q[i] > 8) begin
                idx = int'(((longint'(j) * 64'h6001) & 64'hFF_FFFF) >> 14);
                lo  = model_out(idx);
                hi  = model_out((idx + 1) & 1023);
                vectors++;
                if (int'(so_q[i]) != lo && int'(so_q[i]) != hi) begin
                    miscompares++;
                    $display("FAIL dither_bound j=%0d: got %0d expected %0d or %0d", j, so_q[i], lo, hi);
                end
                if (int'(so_q[i]) != lo) diffs++;
                j++;
            end
        end
        vectors++; if (j !== 64) begin miscompares++; $display("FAIL dither_count: got %0d expected 64", j); end
        vectors++; if (diffs == 0) begin miscompares++; $display("FAIL dither_effect: got 0 differing samples expected at least 1"); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NCO_PHASE_DITHER_EN
        test_dither();
`else
        test_sweep();
        test_handshake();
        test_tick_accept();
        test_phase_clr();
        test_enable();
        test_zero_tw();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
